// File: rtl/gray_ptr_sync_rx.sv
// Receive-side Gray pointer synchronizer for the async FIFO.
// Ports: clk, rst_n, gray_in, err_clr -> bin_out, gray_out, delta, chg, multi_bit_err.
module gray_ptr_sync_rx #(
  parameter int ADDR_WIDTH  = 6,
  parameter int SYNC_STAGES = 2,
  parameter int PIPE_STAGES = 1,
  localparam int W = ADDR_WIDTH + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] gray_in,
  input  logic         err_clr,
  output logic [W-1:0] bin_out,
  output logic [W-1:0] gray_out,
  output logic [W-1:0] delta,
  output logic         chg,
  output logic         multi_bit_err
);

  logic [W-1:0] r_sync [SYNC_STAGES];
  logic [W-1:0] r_prev;

  logic [W-1:0] r_gray [PIPE_STAGES];
  logic [W-1:0] r_bin  [PIPE_STAGES];
  logic [W-1:0] r_dlt  [PIPE_STAGES];
  logic [PIPE_STAGES-1:0] r_chg;
  logic         r_err;

  logic [W-1:0] w_gs;
  logic [W-1:0] w_bin;
  logic [W-1:0] w_pbin;
  logic [W-1:0] w_dlt;
  logic [W-1:0] w_x;
  logic         w_evt;
  logic         w_evt_fin;

  function automatic logic [W-1:0] g2b(
    input logic [W-1:0] g
  );
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= gray_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      r_prev <= w_gs;
    end
  end

  assign w_gs   = r_sync[SYNC_STAGES-1];
  assign w_bin  = g2b(w_gs);
  assign w_pbin = g2b(r_prev);
  assign w_dlt  = w_bin - w_pbin;
  assign w_x    = w_gs ^ r_prev;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_evt  = (w_x & (w_x - W'(1))) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        r_gray[k] <= '0;
        r_bin[k]  <= '0;
        r_dlt[k]  <= '0;
      end
      r_chg <= '0;
    end else begin
      r_gray[0] <= w_gs;
      r_bin[0]  <= w_bin;
      r_dlt[0]  <= w_dlt;
      r_chg[0]  <= w_dlt != '0;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        r_gray[k] <= r_gray[k-1];
        r_bin[k]  <= r_bin[k-1];
        r_dlt[k]  <= r_dlt[k-1];
        r_chg[k]  <= r_chg[k-1];
      end
    end
  end

  // The error event rides the pipe up to the input of the last stage,
  // where it folds into the sticky flag aligned with bin_out.
  if (PIPE_STAGES == 1) begin : g_evt1
    assign w_evt_fin = w_evt;
  end else begin : g_evtn
    logic [PIPE_STAGES-2:0] r_evt;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_evt <= '0;
      end else begin
        r_evt[0] <= w_evt;
        for (int k = 1; k < PIPE_STAGES-1; k++) begin
          r_evt[k] <= r_evt[k-1];
        end
      end
    end
    assign w_evt_fin = r_evt[PIPE_STAGES-2];
  end

  // Set has priority over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_evt_fin | (r_err & ~err_clr);
    end
  end

  assign bin_out       = r_bin[PIPE_STAGES-1];
  assign gray_out      = r_gray[PIPE_STAGES-1];
  assign delta         = r_dlt[PIPE_STAGES-1];
  assign chg           = r_chg[PIPE_STAGES-1];
  assign multi_bit_err = r_err;

endmodule
